// File: rtl/avalon_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_ddr_port_arbiter
// Purpose  : Round-robin arbiter multiplexing NUM_CH Avalon-MM requesters
//            onto one DDR controller port, with write-burst locking and a
//            tag FIFO that routes returning read data to its requester.
// Revision : 1.0  initial release
// ============================================================================
module avalon_ddr_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 64,
  parameter int BURST_W   = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*DATA_W-1:0]   ch_writedata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_byteenable,
  input  logic [NUM_CH*BURST_W-1:0]  ch_burstcount,
  output logic [NUM_CH-1:0]          ch_waitrequest,
  output logic [DATA_W-1:0]          ch_readdata,
  output logic [NUM_CH-1:0]          ch_readdatavalid,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [DATA_W-1:0]          mem_writedata,
  output logic [DATA_W/8-1:0]        mem_byteenable,
  output logic [BURST_W-1:0]         mem_burstcount,
  input  logic                       mem_waitrequest,
  input  logic                       mem_readdatavalid,
  input  logic [DATA_W-1:0]          mem_readdata,
  output logic                       err_orphan
);

  localparam int                 c_ch_w  = $clog2(NUM_CH);
  localparam int                 c_ptr_w = $clog2(TAG_DEPTH);
  localparam int                 c_be_w  = DATA_W / 8;
  localparam logic [c_ch_w-1:0]  c_last_ch = c_ch_w'(NUM_CH - 1);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(TAG_DEPTH);
  localparam logic [BURST_W-1:0] c_one     = BURST_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_ch_w-1:0]    r_grant, r_rr_ptr, w_pick;
  logic [BURST_W-1:0]   r_beat_cnt, r_burst_hold;
  logic                 w_any_elig, w_take_grant, w_release, w_load_burst, w_beat, w_push;
  logic [NUM_CH-1:0]    w_elig;

  // Tag FIFO: one entry per accepted read, holding requester and burst length
  logic [c_ch_w-1:0]    r_tag_ch  [TAG_DEPTH];
  logic [BURST_W-1:0]   r_tag_len [TAG_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic [BURST_W-1:0]   r_head_used;
  logic                 r_err_orphan;
  logic                 w_full, w_empty, w_rd_valid, w_pop;

  // Per-channel views of the packed command buses; a burstcount of 0 means 1
  logic [ADDR_W-1:0]    w_addr  [NUM_CH];
  logic [DATA_W-1:0]    w_wdata [NUM_CH];
  logic [c_be_w-1:0]    w_be    [NUM_CH];
  logic [BURST_W-1:0]   w_blen  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_addr[g]  = ch_address[g*ADDR_W +: ADDR_W];
    assign w_wdata[g] = ch_writedata[g*DATA_W +: DATA_W];
    assign w_be[g]    = ch_byteenable[g*c_be_w +: c_be_w];
    assign w_blen[g]  = (ch_burstcount[g*BURST_W +: BURST_W] == '0) ? c_one
                                                                     : ch_burstcount[g*BURST_W +: BURST_W];
    // A write is always eligible; a read needs a free tag slot
    assign w_elig[g]  = ch_write[g] | (ch_read[g] & ~w_full);
    assign ch_readdatavalid[g] = w_rd_valid && (r_tag_ch[r_rd_ptr] == c_ch_w'(g));
  end

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign w_rd_valid  = mem_readdatavalid & ~w_empty;
  assign w_pop       = w_rd_valid && (r_head_used == r_tag_len[r_rd_ptr] - c_one);
  assign ch_readdata = mem_readdata;
  assign err_orphan  = r_err_orphan;

  // Round-robin pick: scan from the far end so the nearest channel after rr_ptr wins
  always_comb begin
    int idx;
    idx        = 0;
    w_any_elig = 1'b0;
    w_pick     = r_rr_ptr;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(r_rr_ptr) + i) % NUM_CH;
      if (w_elig[c_ch_w'(idx)]) begin
        w_any_elig = 1'b1;
        w_pick     = c_ch_w'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state and command-port muxing; the granted channel owns mem_* until release
  always_comb begin
    w_state_nxt    = r_state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ch_waitrequest = '1;
    mem_address    = w_addr[r_grant];
    mem_writedata  = w_wdata[r_grant];
    mem_byteenable = w_be[r_grant];
    mem_burstcount = w_blen[r_grant];
    w_take_grant   = 1'b0;
    w_release      = 1'b0;
    w_load_burst   = 1'b0;
    w_beat         = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_elig) begin
          w_take_grant = 1'b1;
          w_state_nxt  = CMD;
        end
      end
      CMD: begin
        ch_waitrequest[r_grant] = mem_waitrequest;
        if (ch_write[r_grant]) begin
          mem_write = 1'b1;
          if (!mem_waitrequest) begin
            if (w_blen[r_grant] == c_one) begin
              w_release   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_load_burst = 1'b1;
              w_state_nxt  = WR_BURST;
            end
          end
        end else if (ch_read[r_grant]) begin
          mem_read = 1'b1;
          if (!mem_waitrequest) begin
            w_push      = 1'b1;
            w_release   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WR_BURST: begin
        ch_waitrequest[r_grant] = mem_waitrequest;
        mem_write      = ch_write[r_grant];
        mem_burstcount = r_burst_hold;
        if (ch_write[r_grant] && !mem_waitrequest) begin
          w_beat = 1'b1;
          if (r_beat_cnt == c_one) begin
            w_release   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant, round-robin pointer and write-burst beat tracking
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_grant      <= '0;
      r_rr_ptr     <= c_last_ch;
      r_beat_cnt   <= '0;
      r_burst_hold <= '0;
    end else begin
      if (w_take_grant) r_grant  <= w_pick;
      if (w_release)    r_rr_ptr <= r_grant;
      if (w_load_burst) begin
        r_beat_cnt   <= w_blen[r_grant] - c_one;
        r_burst_hold <= w_blen[r_grant];
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt - c_one;
      end
    end
  end

  // Tag FIFO control, head beat counter and sticky orphan flag
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_used  <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop)           r_head_used <= '0;
      else if (w_rd_valid) r_head_used <= r_head_used + c_one;
      if (mem_readdatavalid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while occupancy covers them
  always_ff @(posedge clk_clk) begin
    if (w_push) begin
      r_tag_ch[r_wr_ptr]  <= r_grant;
      r_tag_len[r_wr_ptr] <= w_blen[r_grant];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_ddr_port_arbiter
// Purpose  : Directed scenarios against avalon_ddr_port_arbiter, checked every
//            cycle by a transaction-level model and by literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_avalon_ddr_port_arbiter;
  localparam int NUM_CH = 4, ADDR_W = 27, DATA_W = 64, BURST_W = 4, TAG_DEPTH = 8;

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic [NUM_CH*ADDR_W-1:0]   ch_address;
  logic [NUM_CH-1:0]          ch_read, ch_write;
  logic [NUM_CH*DATA_W-1:0]   ch_writedata;
  logic [NUM_CH*DATA_W/8-1:0] ch_byteenable;
  logic [NUM_CH*BURST_W-1:0]  ch_burstcount;
  logic [NUM_CH-1:0]          ch_waitrequest, ch_readdatavalid;
  logic [DATA_W-1:0]          ch_readdata, mem_writedata, mem_readdata;
  logic [ADDR_W-1:0]          mem_address;
  logic                       mem_read, mem_write, err_orphan;
  logic [DATA_W/8-1:0]        mem_byteenable;
  logic [BURST_W-1:0]         mem_burstcount;
  logic                       mem_waitrequest, mem_readdatavalid;

  // Per-channel stimulus, packed onto the DUT buses below
  logic [ADDR_W-1:0]   tb_addr  [NUM_CH];
  logic [DATA_W-1:0]   tb_wdata [NUM_CH];
  logic [DATA_W/8-1:0] tb_be    [NUM_CH];
  logic [BURST_W-1:0]  tb_bc    [NUM_CH];
  logic [NUM_CH-1:0]   tb_rd, tb_wr;

  always_comb begin
    ch_read  = tb_rd;
    ch_write = tb_wr;
    ch_address = '0; ch_writedata = '0; ch_byteenable = '0; ch_burstcount = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_address[i*ADDR_W +: ADDR_W]           = tb_addr[i];
      ch_writedata[i*DATA_W +: DATA_W]         = tb_wdata[i];
      ch_byteenable[i*(DATA_W/8) +: DATA_W/8]  = tb_be[i];
      ch_burstcount[i*BURST_W +: BURST_W]      = tb_bc[i];
    end
  end

  avalon_ddr_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write),
    .ch_writedata(ch_writedata), .ch_byteenable(ch_byteenable), .ch_burstcount(ch_burstcount),
    .ch_waitrequest(ch_waitrequest), .ch_readdata(ch_readdata), .ch_readdatavalid(ch_readdatavalid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_burstcount(mem_burstcount),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata), .err_orphan(err_orphan)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Model: who owns the port, which beats remain, and a queue of read tags
  // (requester, beats still owed). Evaluated on the falling edge, when the
  // inputs for the cycle are stable; the resulting ownership applies next cycle.
  // ------------------------------------------------------------------------
  int  m_st;          // 0 = nobody owns the port, 1 = command phase, 2 = write burst
  int  m_grant, m_rr, m_beats_left, m_bhold;
  bit  m_orph;
  int  q_ch[$];
  int  q_left[$];
  logic [NUM_CH-1:0] e_wait, e_rdv;
  logic e_rd, e_wr;
  int  g, c;
  bit  full_now, found;

  function automatic int nlen(input int ch);
    return (tb_bc[ch] == '0) ? 1 : int'(tb_bc[ch]);
  endfunction

  always @(negedge clk_clk) begin
    if (reset_reset) begin
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_waitrequest", ch_waitrequest, 4'hF);
      chk("rst_readdatavalid", ch_readdatavalid, 0);
      chk("rst_err_orphan", err_orphan, 0);
      m_st = 0; m_rr = NUM_CH - 1; m_grant = 0; m_beats_left = 0; m_bhold = 0; m_orph = 0;
      q_ch.delete(); q_left.delete();
    end else begin
      g = m_grant;
      e_rd = 1'b0; e_wr = 1'b0; e_wait = '1; e_rdv = '0;
      if (m_st != 0) begin
        e_wait[g] = mem_waitrequest;
        e_wr = tb_wr[g];
        e_rd = (m_st == 1) && !tb_wr[g] && tb_rd[g];
        chk("mem_address", mem_address, tb_addr[g]);
        chk("mem_writedata", mem_writedata, tb_wdata[g]);
        chk("mem_byteenable", mem_byteenable, tb_be[g]);
        chk("mem_burstcount", mem_burstcount, (m_st == 2) ? m_bhold : nlen(g));
      end
      if (mem_readdatavalid && q_ch.size() > 0) begin
        e_rdv[q_ch[0]] = 1'b1;
        chk("ch_readdata", ch_readdata, mem_readdata);
      end
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      chk("ch_waitrequest", ch_waitrequest, e_wait);
      chk("ch_readdatavalid", ch_readdatavalid, e_rdv);
      chk("err_orphan", err_orphan, m_orph);

      full_now = (q_ch.size() == TAG_DEPTH);
      if (mem_readdatavalid) begin
        if (q_ch.size() > 0) begin
          q_left[0] = q_left[0] - 1;
          if (q_left[0] == 0) begin
            void'(q_ch.pop_front());
            void'(q_left.pop_front());
          end
        end else begin
          m_orph = 1'b1;
        end
      end
      case (m_st)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_rr + k) % NUM_CH;
            if (!found && (tb_wr[c] || (tb_rd[c] && !full_now))) begin
              found = 1'b1; m_grant = c; m_st = 1;
            end
          end
        end
        1: if (!mem_waitrequest) begin
          if (tb_wr[g]) begin
            if (nlen(g) == 1) begin m_rr = g; m_st = 0; end
            else begin m_beats_left = nlen(g) - 1; m_bhold = nlen(g); m_st = 2; end
          end else if (tb_rd[g]) begin
            q_ch.push_back(g); q_left.push_back(nlen(g)); m_rr = g; m_st = 0;
          end
        end
        default: if (tb_wr[g] && !mem_waitrequest) begin
          m_beats_left--;
          if (m_beats_left == 0) begin m_rr = g; m_st = 0; end
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_clk); #1;
  endtask

  task automatic clear_req();
    tb_rd = '0; tb_wr = '0;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1; clear_req(); tick(); tick(); reset_reset = 1'b0;
  endtask

  task automatic wait_idle_and_clear();
    for (int k = 0; k < 50 && m_st != 0; k++) tick();
    chk("idle_reached", m_st == 0, 1);
    clear_req();
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && q_ch.size() > 0; k++) begin
      mem_readdatavalid = 1'b1; mem_readdata = {$urandom, $urandom}; tick();
    end
    mem_readdatavalid = 1'b0;
    chk("drain_done", q_ch.size(), 0);
  endtask

  int g_ch[8], g_at[8], n_g;
  int beats, held, last_beat, ch2_at, n_acc, first_after;
  logic [NUM_CH-1:0] rec[4];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
    tb_rd = '0; tb_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tb_addr[i]  = 27'h2A5F00 | 27'(i);
      tb_wdata[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 17 + 3);
      tb_be[i]    = 8'hF0 ^ 8'(i);
      tb_bc[i]    = 4'd1;
    end
    do_reset();

    // S1: four continuous single-beat readers -> grants 0,1,2,3,0, two cycles apart
    tb_rd = 4'hF; n_g = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); #2;
      if (mem_read && !mem_waitrequest && n_g < 8) begin
        g_ch[n_g] = int'(mem_address[3:0]); g_at[n_g] = i; n_g++;
      end
    end
    chk("s1_grant_count", n_g, 6);
    chk("s1_g0", g_ch[0], 0); chk("s1_g1", g_ch[1], 1); chk("s1_g2", g_ch[2], 2);
    chk("s1_g3", g_ch[3], 3); chk("s1_g4", g_ch[4], 0);
    for (int k = 1; k < 5; k++) chk("s1_spacing", g_at[k] - g_at[k-1], 2);
    wait_idle_and_clear();
    drain();

    // S2: ch1 4-beat write with a stall on beat 2 while ch2 waits to read
    do_reset();
    tb_wr[1] = 1'b1; tb_bc[1] = 4'd4; tb_rd[2] = 1'b1;
    beats = 0; held = 0; last_beat = -1; ch2_at = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      mem_waitrequest = (i == 1);
      if (i == 2) tb_bc[1] = 4'd1;  // burst length must stay latched mid-burst
      if (i == 7) clear_req();
      #2;
      if (mem_write && mem_address[3:0] == 4'd1) begin
        if (mem_waitrequest) held++;
        else begin beats++; last_beat = i; end
      end
      if (mem_read && !mem_waitrequest && mem_address[3:0] == 4'd2) ch2_at = i;
    end
    mem_waitrequest = 1'b0;
    chk("s2_beats", beats, 4);
    chk("s2_held", held, 1);
    chk("s2_last_beat", last_beat, 4);
    chk("s2_ch2_grant", ch2_at, 6);
    tb_bc[1] = 4'd1;
    wait_idle_and_clear();
    drain();

    // S3: tag FIFO full after 8 reads; one return frees a slot for the next IDLE
    do_reset();
    tb_rd[0] = 1'b1; n_acc = 0; first_after = -1;
    for (int i = 0; i < 21; i++) begin
      tick();
      mem_readdatavalid = (i == 17);
      mem_readdata = 64'h1234_5678_9ABC_DEF0;
      if (i == 20) clear_req();
      #2;
      if (mem_read && !mem_waitrequest) begin
        if (i < 17) n_acc++;
        else if (first_after < 0) first_after = i;
      end
    end
    mem_readdatavalid = 1'b0;
    chk("s3_reads_before_full", n_acc, 8);
    chk("s3_first_after_pop", first_after, 19);

    // Reset with 8 reads outstanding: a later return is an orphan (S5)
    do_reset();
    mem_readdatavalid = 1'b1; #2;
    chk("s5_rdv_none", ch_readdatavalid, 0);
    tick(); mem_readdatavalid = 1'b0; #2;
    chk("s5_err_set", err_orphan, 1);
    repeat (5) tick();
    chk("s5_err_hold", err_orphan, 1);

    // S4: ch3 burst-2 read then ch0 read with burstcount 0 (one beat)
    do_reset();
    tb_rd[3] = 1'b1; tb_bc[3] = 4'd2;
    tick();
    tick(); tb_rd[3] = 1'b0; tb_rd[0] = 1'b1; tb_bc[0] = 4'd0;
    tick();
    tick(); clear_req();
    for (int k = 0; k < 4; k++) begin
      tick(); mem_readdatavalid = 1'b1; mem_readdata = 64'hA5A5_0000_0000_0000 | 64'(k); #2;
      rec[k] = ch_readdatavalid;
    end
    tick(); mem_readdatavalid = 1'b0; #2;
    chk("s4_beat0", rec[0], 4'b1000);
    chk("s4_beat1", rec[1], 4'b1000);
    chk("s4_beat2", rec[2], 4'b0001);
    chk("s4_extra_beat", rec[3], 4'b0000);
    chk("s4_err_set", err_orphan, 1);
    tb_bc[0] = 4'd1; tb_bc[3] = 4'd1;

    // S6: reset asserted during beat 2 of a write burst
    tb_wr[1] = 1'b1; tb_bc[1] = 4'd4;
    tick(); tick(); #1;
    chk("s6_burst_active", mem_write, 1);
    reset_reset = 1'b1; #1;
    chk("s6_mem_write", mem_write, 0);
    chk("s6_waitrequest", ch_waitrequest, 4'hF);
    chk("s6_err_cleared", err_orphan, 0);
    clear_req();
    tick(); reset_reset = 1'b0; tick(); #2;
    chk("s6_after_mem_write", mem_write, 0);
    chk("s6_after_rdv", ch_readdatavalid, 0);
    tb_bc[1] = 4'd1;

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avalon_ddr_port_arbiter.md
AVALON_DDR_PORT_ARBITER -- requirements
Module: avalon_ddr_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of Avalon-MM requester channels, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 27: word address width.
REQ-003 SHALL have parameter DATA_W, default 64: data width; byteenable width is DATA_W/8.
REQ-004 SHALL have parameter BURST_W, default 4: burstcount width; maximum burst is 2^(BURST_W-1) beats.
REQ-005 SHALL have parameter TAG_DEPTH, default 8: outstanding-read tag FIFO depth, power of two.
REQ-006 SHALL have one clock, with an asynchronous, active-high reset.
REQ-007 SHALL have the following ports, clock and reset first:
- clk_clk  in  1  sole clock; all logic rising-edge.
- reset_reset  in  1  asynchronous active-high reset.
- ch_address  in  NUM_CH*ADDR_W  per-channel address, channel i at slice i.
- ch_read / ch_write  in  NUM_CH each  per-channel command strobes.
- ch_writedata  in  NUM_CH*DATA_W  per-channel write data.
- ch_byteenable  in  NUM_CH*DATA_W/8  per-channel byte enables.
- ch_burstcount  in  NUM_CH*BURST_W  per-channel burst length.
- ch_waitrequest  out  NUM_CH  per-channel stall.
- ch_readdata  out  DATA_W  read data, broadcast to all channels.
- ch_readdatavalid  out  NUM_CH  one-hot read-data strobe.
- mem_address, mem_read, mem_write, mem_writedata, mem_byteenable, mem_burstcount  out  (as channel widths)  command to the DDR controller Avalon-MM slave.
- mem_waitrequest, mem_readdatavalid  in  1 each  controller handshake.
- mem_readdata  in  DATA_W  controller read data.
- err_orphan  out  1  sticky flag: read data arrived with no outstanding tag.

Function
REQ-008 SHALL implement FSM states IDLE, CMD, WR_BURST.
REQ-009 In IDLE, a channel SHALL be eligible when ch_write is asserted, or when ch_read is asserted and the tag FIFO is not full.
REQ-010 In IDLE with any eligible channel, SHALL register grant to the first eligible channel searching upward (modulo NUM_CH) from rr_ptr+1, then enter CMD; arbitration costs exactly one cycle.
REQ-011 In CMD and WR_BURST, mem_* command outputs SHALL be the granted channel's inputs; ch_waitrequest[grant] SHALL equal mem_waitrequest; all other ch_waitrequest bits SHALL be 1.
REQ-012 In IDLE, mem_read and mem_write SHALL be 0, and all ch_waitrequest bits SHALL be 1.
REQ-013 A read accepted in CMD (mem_read & !mem_waitrequest) SHALL push {grant, burstcount} to the tag FIFO, set rr_ptr=grant, and return to IDLE.
REQ-014 A write accepted in CMD with burstcount==1 SHALL set rr_ptr=grant and return to IDLE.
REQ-015 A write accepted in CMD with burstcount>1 SHALL load beat_cnt=burstcount-1 and enter WR_BURST.
REQ-016 In WR_BURST, each accepted beat SHALL decrement beat_cnt; the beat accepted at beat_cnt==1 SHALL set rr_ptr=grant and return to IDLE. Grant SHALL NOT change mid-burst.
REQ-017 If a channel asserts both ch_read and ch_write, write SHALL take precedence.
REQ-018 A burstcount of 0 SHALL be treated as 1.
REQ-019 mem_burstcount SHALL be held at the CMD-cycle value throughout WR_BURST.
REQ-020 On mem_readdatavalid with the tag FIFO non-empty, SHALL drive ch_readdatavalid one-hot on the head tag's channel and pass mem_readdata to ch_readdata, both combinationally (zero latency).
REQ-021 The head tag's remaining-beat counter SHALL decrement per valid beat; the FIFO SHALL pop on the last beat.
REQ-022 A push and a pop in the same cycle SHALL both take effect, with occupancy unchanged; a full FIFO with a simultaneous pop still SHALL NOT accept a new read grant in that IDLE cycle (full evaluated on registered occupancy).
REQ-023 mem_readdatavalid with the FIFO empty SHALL assert no ch_readdatavalid bit and SHALL set err_orphan, which holds until reset.
REQ-024 FIFO pointers SHALL wrap modulo TAG_DEPTH; occupancy SHALL be 0..TAG_DEPTH inclusive.

Reset
REQ-025 Reset SHALL force state IDLE, rr_ptr=NUM_CH-1 (channel 0 first), beat_cnt=0, FIFO empty, and err_orphan=0; outputs SHALL then be mem_read=0, mem_write=0, all ch_waitrequest=1, and ch_readdatavalid=0.
REQ-026 Reset asserted mid-burst or with reads outstanding SHALL discard all state; no ch_readdatavalid SHALL be produced for pre-reset reads.

Verification
REQ-027 Bench SHALL cover these scenarios:
- Ch0..ch3 all assert ch_read with burstcount 1 continuously, and mem_waitrequest=0 -> grants 0,1,2,3,0 on successive CMD cycles, with 2 cycles per grant.
- Ch1 writes burstcount 4 while ch2 requests, and mem_waitrequest is high on beat 2 -> 4 beats on mem, all from ch1, with beat 2 held; ch2 is granted only after beat 4.
- 8 single-beat reads issued (TAG_DEPTH=8) with no returns -> 9th read is not granted; the first mem_readdatavalid pops one tag, and the next IDLE grants.
- Ch3 read burstcount 2, then ch0 read burstcount 1; 3 return beats -> ch_readdatavalid = 1000, 1000, 0001.
- mem_readdatavalid pulse with FIFO empty -> ch_readdatavalid=0 and err_orphan=1, held until reset.
- Reset asserted during WR_BURST beat 2 -> next cycle: mem_write=0, all ch_waitrequest=1, and err_orphan=0.
